// File: rtl/call_reg.sv
// Elevator call register: latches button presses, serves calls at the current
// floor directly, and offers the next target floor to the motion controller.
module call_reg #(
    parameter int NFLOOR = 4,
    parameter int FW     = 2
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [NFLOOR-1:0] pbpulse,
    input  logic [FW-1:0]     cur_floor,
    input  logic              dir_up,
    input  logic              arrived,
    input  logic              req_ack,
    output logic [NFLOOR-1:0] pending,
    output logic              req_valid,
    output logic [FW-1:0]     req_floor,
    output logic              open_pulse
);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    state_t            state_reg, state_next;
    logic [NFLOOR-1:0] prev_reg;
    logic [NFLOOR-1:0] pending_reg, pending_next;
    logic [FW-1:0]     req_floor_reg, req_floor_next;
    logic              open_pulse_reg, open_pulse_next;

    logic [NFLOOR-1:0] set_ev;
    logic [NFLOOR-1:0] cur_hot;
    logic [NFLOOR-1:0] clr_vec;
    logic              cur_pending;
    logic              serve_here;
    logic              load_target;
    logic              target_hit;

    logic [FW-1:0]     above_floor, below_floor, sel_floor;
    logic              found_above, found_below;

    // cur_hot stays all-zero when cur_floor is beyond the last floor
    for (genvar gi = 0; gi < NFLOOR; gi++) begin : g_floor
        assign set_ev[gi]  = pbpulse[gi] & ~prev_reg[gi];
        assign cur_hot[gi] = (int'(cur_floor) == gi);
    end

    assign cur_pending = |(cur_hot & pending_reg);
    assign target_hit  = arrived && (cur_floor == req_floor_reg);

    // Clears are applied after sets so a clear always wins on the same floor
    assign clr_vec      = (arrived ? cur_hot : '0) | (serve_here ? cur_hot : '0);
    assign pending_next = (pending_reg | set_ev) & ~clr_vec;

    always_comb begin
        above_floor = '0;
        found_above = 1'b0;
        below_floor = '0;
        found_below = 1'b0;
        for (int i = NFLOOR - 1; i >= 0; i--) begin
            if (pending_reg[i] && (i > int'(cur_floor))) begin
                above_floor = FW'(i);
                found_above = 1'b1;
            end
        end
        for (int i = 0; i < NFLOOR; i++) begin
            if (pending_reg[i] && (i < int'(cur_floor))) begin
                below_floor = FW'(i);
                found_below = 1'b1;
            end
        end
        if (dir_up)
            sel_floor = found_above ? above_floor : below_floor;
        else
            sel_floor = found_below ? below_floor : above_floor;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!cur_pending && (|pending_reg))
                    state_next = OFFER;
            end
            OFFER: begin
                // Losing the target before the ack withdraws the offer
                if (target_hit)
                    state_next = IDLE;
                else if (req_ack)
                    state_next = BUSY;
            end
            BUSY: begin
                if (target_hit)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        serve_here      = (state_reg == IDLE) && cur_pending;
        load_target     = (state_reg == IDLE) && !cur_pending && (|pending_reg);
        req_floor_next  = load_target ? sel_floor : req_floor_reg;
        open_pulse_next = serve_here;
        req_valid       = (state_reg == OFFER);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            prev_reg       <= '0;
            pending_reg    <= '0;
            req_floor_reg  <= '0;
            open_pulse_reg <= 1'b0;
        end else begin
            prev_reg       <= pbpulse;
            pending_reg    <= pending_next;
            req_floor_reg  <= req_floor_next;
            open_pulse_reg <= open_pulse_next;
        end
    end

    assign pending    = pending_reg;
    assign req_floor  = req_floor_reg;
    assign open_pulse = open_pulse_reg;

endmodule

// File: tb/tb_call_reg.sv
// Directed bench for call_reg: a per-cycle vector table plus hand-written
// asynchronous reset sequences.
module tb_call_reg;

    logic       clk = 1'b0;
    logic       resetb;
    logic [3:0] pbpulse;
    logic [1:0] cur_floor;
    logic       dir_up;
    logic       arrived;
    logic       req_ack;
    logic [3:0] pending;
    logic       req_valid;
    logic [1:0] req_floor;
    logic       open_pulse;

    int n_vec = 0;
    int n_bad = 0;

    call_reg #(.NFLOOR(4), .FW(2)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .pbpulse    (pbpulse),
        .cur_floor  (cur_floor),
        .dir_up     (dir_up),
        .arrived    (arrived),
        .req_ack    (req_ack),
        .pending    (pending),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
        .open_pulse (open_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pb;
        logic [1:0] cur;
        logic       up;
        logic       arr;
        logic       ack;
        logic [3:0] e_pend;
        logic       e_valid;
        logic [1:0] e_floor;
        logic       e_open;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] pb, input logic [1:0] cur, input logic up,
                       input logic arr, input logic ack, input logic [3:0] e_pend,
                       input logic e_valid, input logic [1:0] e_floor, input logic e_open);
        vec_t v;
        v.pb = pb; v.cur = cur; v.up = up; v.arr = arr; v.ack = ack;
        v.e_pend = e_pend; v.e_valid = e_valid; v.e_floor = e_floor; v.e_open = e_open;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_pend, input logic e_valid,
                             input logic [1:0] e_floor, input logic e_open);
        check({tag, ".pending"},    32'(pending),    32'(e_pend));
        check({tag, ".req_valid"},  32'(req_valid),  32'(e_valid));
        check({tag, ".req_floor"},  32'(req_floor),  32'(e_floor));
        check({tag, ".open_pulse"}, 32'(open_pulse), 32'(e_open));
    endtask

    initial begin
        //    pb       cur  up    arr   ack  | pend    vld   flr  open
        // held press of floor 2 from floor 0, offer, ack, arrive; no re-set
        add(4'b0100, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0);
        add(4'b0100, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0100, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0);
        add(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        add(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        add(4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        // pending 1010 at floor 2 going up -> 3; stable across new press; withdraw
        add(4'b1010, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 2'd2, 1'b0);
        add(4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 1'b0);
        add(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 1'b0);
        add(4'b0001, 2'd2, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 2'd3, 1'b0);
        add(4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 2'd3, 1'b0);
        // going down from 2 -> 1; ack in BUSY ignored; arrival elsewhere keeps BUSY
        add(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 2'd1, 1'b0);
        add(4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 2'd1, 1'b0);
        add(4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b0);
        add(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b0);
        add(4'b0000, 2'd1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
        // offer 3 with floor 1 pending; arrive at 1 stays BUSY, arrive at 3 ends
        add(4'b1010, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 2'd1, 1'b0);
        add(4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 2'd3, 1'b0);
        add(4'b0000, 2'd2, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd3, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        // press at current floor: one cycle pending, then one open pulse
        add(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd3, 1'b0);
        add(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1);
        add(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        // set and clear on floor 2 in the same cycle: clear wins
        add(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        // down with nothing below -> lowest above
        add(4'b1000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        // up with nothing above -> highest below; then fill to 1111 in OFFER
        add(4'b0011, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd3, 1'b0);
        add(4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 2'd1, 1'b0);
        add(4'b1100, 2'd3, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b0);

        resetb = 1'b0; pbpulse = '0; cur_floor = '0; dir_up = 1'b1; arrived = 1'b0; req_ack = 1'b0;
        #1;
        check_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        resetb = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            pbpulse = vecs[i].pb; cur_floor = vecs[i].cur; dir_up = vecs[i].up;
            arrived = vecs[i].arr; req_ack = vecs[i].ack;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_valid,
                      vecs[i].e_floor, vecs[i].e_open);
            $display("vec%0d pb=%b cur=%0d up=%b arr=%b ack=%b -> pend=%b vld=%b flr=%0d open=%b",
                     i, vecs[i].pb, vecs[i].cur, vecs[i].up, vecs[i].arr, vecs[i].ack,
                     pending, req_valid, req_floor, open_pulse);
        end

        // asynchronous reset in the middle of an offer with all floors pending
        pbpulse = '0; arrived = 1'b0; req_ack = 1'b0;
        #2;
        resetb = 1'b0;
        #1;
        check_all("async_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        resetb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("post_reset%0d", c), 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        // a button already high at reset release is a fresh press
        @(negedge clk);
        cur_floor = 2'd0; dir_up = 1'b1;
        pbpulse = 4'b0100;
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk);
        #1;
        check_all("held_at_release", 4'b0100, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check_all("held_offer", 4'b0100, 1'b1, 2'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/call_reg.md
CALL_REG -- requirements
Module: call_reg

Interface
REQ-001 SHALL have parameter NFLOOR, default 4, number of floors/call buttons.
REQ-002 SHALL have parameter FW, default 2, floor-index width; ceil(log2(NFLOOR)) <= FW.
REQ-003 clk  input  1  system clock.
REQ-004 resetb  input  1  reset, asynchronous, active-low.
REQ-005 pbpulse  input  NFLOOR  per-floor button pulses; may stay high for many clk cycles.
REQ-006 cur_floor  input  FW  floor the car is currently at or passing.
REQ-007 dir_up  input  1  current travel preference: 1 = up, 0 = down.
REQ-008 arrived  input  1  single-cycle strobe: car stopped at cur_floor, doors opening.
REQ-009 req_ack  input  1  controller accepts the offered target.
REQ-010 pending  output  NFLOOR  latched call requests; drives button lamps.
REQ-011 req_valid  output  1  target offer valid.
REQ-012 req_floor  output  FW  offered target floor.
REQ-013 open_pulse  output  1  single-cycle: call at current floor served without travel.

Function
REQ-014 Per floor i, SHALL register pbpulse[i] into prev[i] every clk; set event = pbpulse[i] & !prev[i].
REQ-015 Set event SHALL set pending[i] on the same clk edge, visible one cycle after the first high cycle of pbpulse[i].
REQ-016 A held-high pbpulse[i] SHALL NOT re-set pending[i] after it is cleared.
REQ-017 arrived with cur_floor < NFLOOR SHALL clear pending[cur_floor]; cur_floor >= NFLOOR SHALL clear nothing.
REQ-018 Set event and clear on the same floor in the same cycle: clear SHALL win.
REQ-019 Set event on an already-pending floor SHALL have no effect.
REQ-020 FSM states: IDLE, OFFER, BUSY; reset state IDLE.
REQ-021 IDLE, pending[cur_floor]=1: SHALL clear that bit and assert open_pulse for one cycle; SHALL stay in IDLE; this takes priority over offering.
REQ-022 IDLE, otherwise pending != 0: SHALL load req_floor with the selected target and go to OFFER; req_valid high from the next cycle.
REQ-023 Selection when dir_up=1: lowest pending floor above cur_floor; if none, highest pending floor below.
REQ-024 Selection when dir_up=0: highest pending floor below cur_floor; if none, lowest pending floor above.
REQ-025 OFFER: req_valid=1; req_floor SHALL stay stable until req_ack; new presses SHALL NOT change req_floor.
REQ-026 OFFER with req_ack=1: SHALL go to BUSY; req_valid low from the next cycle.
REQ-027 OFFER, target bit cleared by arrived before ack: SHALL withdraw req_valid and return to IDLE.
REQ-028 BUSY: arrived with cur_floor == req_floor SHALL clear that bit and return to IDLE.
REQ-029 BUSY: arrived at another floor SHALL clear only that floor's bit and stay in BUSY.
REQ-030 req_ack outside OFFER SHALL be ignored.
REQ-031 open_pulse SHALL be asserted only from IDLE and never for more than one consecutive cycle per served call.

Reset
REQ-032 resetb low SHALL immediately force pending=0, prev=0, req_valid=0, req_floor=0, open_pulse=0, state IDLE.
REQ-033 Reset asserted mid-offer or mid-BUSY SHALL discard all calls; no output glitch on release.
REQ-034 After release, a pbpulse already high SHALL count as a new set event.

Verification
REQ-035 NFLOOR=4, cur_floor=0, dir_up=1, pbpulse[2] high 10 cycles -> pending=0100 next cycle; req_valid=1, req_floor=2 two cycles later; held pulse causes no re-set after the clear.
REQ-036 pending=1010, cur_floor=2, dir_up=1 -> req_floor=3; with dir_up=0 -> req_floor=1.
REQ-037 Offer floor 3, req_ack, arrived at cur_floor=1 (pending bit 1 set) -> pending[1] cleared, still BUSY; arrived at cur_floor=3 -> pending[3]=0, IDLE.
REQ-038 IDLE, cur_floor=1, press floor 1 -> pending[1] high one cycle, then open_pulse=1 for exactly one cycle, req_valid stays 0.
REQ-039 Press floor 2 set event in the same cycle as arrived with cur_floor=2 -> pending[2]=0.
REQ-040 resetb low during OFFER with pending=1111 -> all outputs 0 asynchronously; after release with pbpulse=0000 -> state stays IDLE.
